// File: rtl/mpu6050_pkg.sv
// Shared constants for the MPU6050 burst reader: register map, FSM encoding,
// output word indices and the big-endian word assembly helper.
package mpu6050_pkg;

  localparam logic [6:0] MPU_ADDR         = 7'h68;
  localparam logic [7:0] REG_ACCEL_XOUT_H = 8'h3B;
  localparam logic [7:0] REG_PWR_MGMT_1   = 8'h6B;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_REQ      = 3'd1;
  localparam logic [2:0] ST_CAPTURE  = 3'd2;
  localparam logic [2:0] ST_STOP_REQ = 3'd3;
  localparam logic [2:0] ST_PUBLISH  = 3'd4;

  localparam int W_ACCEL_X  = 0;
  localparam int W_ACCEL_Y  = 1;
  localparam int W_ACCEL_Z  = 2;
  localparam int W_TEMP     = 3;
  localparam int W_GYRO_X   = 4;
  localparam int W_GYRO_Y   = 5;
  localparam int W_GYRO_Z   = 6;
  localparam int NUM_WORDS  = 7;
  localparam int MAX_BYTES  = 14;

  function automatic logic [15:0] be_word(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/mpu_sample_timer.sv
// Free-running sample period counter with a pending latch that collapses
// multiple ticks into one request until the sequencer consumes it.
module mpu_sample_timer #(
  parameter int unsigned SAMPLE_PERIOD = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic consume_i,
  output logic tick_o,
  output logic pending_o
);

  localparam int CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_PERIOD - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             pending_q;
  logic             pending_d;

  // A fresh tick wins over a same-cycle consume so it is never lost.
  always_comb begin
    tick_o = (count_q == LAST);
    if (tick_o) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
    pending_d = tick_o | (pending_q & ~consume_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/mpu6050_burst_reader.sv
// Periodic MPU6050 burst-read sequencer in front of the I2C master.
// Optional watchdog: define MPU_READ_TIMEOUT_EN.
module mpu6050_burst_reader
  import mpu6050_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned SAMPLE_PERIOD  = 500_000,
  parameter logic [6:0]  SLAVE_ADDR     = MPU_ADDR,
  parameter logic [7:0]  START_REG      = REG_ACCEL_XOUT_H,
  parameter int unsigned NUM_BYTES      = 14,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  output logic               i2c_start,
  output logic               i2c_stop,
  output logic [6:0]         i2c_slave_address,
  output logic [7:0]         i2c_reg_addr,
  input  logic [7:0]         i2c_data,
  input  logic               i2c_avail_data,
  input  logic               i2c_avail,
  output logic signed [15:0] accel_x,
  output logic signed [15:0] accel_y,
  output logic signed [15:0] accel_z,
  output logic signed [15:0] temp_raw,
  output logic signed [15:0] gyro_x,
  output logic signed [15:0] gyro_y,
  output logic signed [15:0] gyro_z,
  output logic               sample_valid,
  output logic               busy,
  output logic               error
);

  if ((NUM_BYTES < 2) || (NUM_BYTES > MAX_BYTES) || (NUM_BYTES % 2 != 0) ||
      (CLK_HZ == 0) || (TIMEOUT_CYCLES == 0)) begin : g_bad_cfg
    $error("mpu6050_burst_reader: invalid parameter set");
  end

  localparam logic [3:0] NB = 4'(NUM_BYTES);

  logic [2:0]  state_q, state_d;
  logic [3:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  shadow_q [MAX_BYTES];
  logic [15:0] words_q [NUM_WORDS];
  logic        avail_data_q, avail_data_qq;
  logic        sample_valid_q;
  logic        consume, capture, publish, rise, pending, aborted;

  mpu_sample_timer #(.SAMPLE_PERIOD(SAMPLE_PERIOD)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .consume_i (consume),
    .tick_o    (),
    .pending_o (pending)
  );

  assign rise = avail_data_q & ~avail_data_qq;

`ifdef MPU_READ_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0] wd_q;
  logic            wd_hit, abort_q, err_q;
  assign wd_hit  = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign aborted = abort_q;
  assign error   = err_q;
`else
  assign aborted = 1'b0;
  assign error   = 1'b0;
`endif

  // Sequencer next-state; the watchdog overlay overrides the normal flow.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    consume    = 1'b0;
    capture    = 1'b0;
    publish    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending && enable && i2c_avail) begin
          state_d = ST_REQ;
          consume = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (!i2c_avail) begin
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_CAPTURE: begin
        if (byte_idx_q == NB) begin
          state_d = ST_STOP_REQ;
        end else if (rise) begin
          capture    = 1'b1;
          byte_idx_d = byte_idx_q + 4'd1;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_STOP_REQ: begin
        if (i2c_avail && aborted) begin
          state_d    = ST_IDLE;
          byte_idx_d = 4'd0;
        end else if (i2c_avail) begin
          state_d = ST_PUBLISH;
        end else begin
          state_d = ST_STOP_REQ;
        end
      end
      ST_PUBLISH: begin
        publish    = 1'b1;
        byte_idx_d = 4'd0;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        byte_idx_d = 4'd0;
      end
    endcase
`ifdef MPU_READ_TIMEOUT_EN
    if (wd_hit && ((state_q == ST_REQ) || (state_q == ST_CAPTURE))) begin
      state_d    = ST_STOP_REQ;
      capture    = 1'b0;
      byte_idx_d = 4'd0;
    end else if (wd_hit && (state_q == ST_STOP_REQ) && !i2c_avail) begin
      state_d    = ST_IDLE;
      byte_idx_d = 4'd0;
    end else begin
      state_d = state_d;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      byte_idx_q     <= 4'd0;
      avail_data_q   <= 1'b0;
      avail_data_qq  <= 1'b0;
      sample_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      byte_idx_q     <= byte_idx_d;
      avail_data_q   <= i2c_avail_data;
      avail_data_qq  <= avail_data_q;
      sample_valid_q <= publish;
    end
  end

  // Shadow buffer fills during CAPTURE; outputs move only on PUBLISH, all at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_BYTES; i++) shadow_q[i] <= 8'h00;
      for (int k = 0; k < NUM_WORDS; k++) words_q[k] <= 16'h0000;
    end else begin
      if (capture) begin
        shadow_q[byte_idx_q] <= i2c_data;
      end
      for (int k = 0; k < NUM_WORDS; k++) begin
        if (publish && ((2 * k + 1) < NUM_BYTES)) begin
          words_q[k] <= be_word(shadow_q[2*k], shadow_q[2*k+1]);
        end
      end
    end
  end

`ifdef MPU_READ_TIMEOUT_EN
  // Watchdog restarts on each hit so STOP_REQ gets its own full window.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q    <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) || wd_hit) begin
        wd_q <= '0;
      end else begin
        wd_q <= wd_q + WD_W'(1);
      end
      if (wd_hit && ((state_q == ST_REQ) || (state_q == ST_CAPTURE))) begin
        abort_q <= 1'b1;
        err_q   <= 1'b1;
      end else if (state_d == ST_IDLE) begin
        abort_q <= 1'b0;
      end else begin
        abort_q <= abort_q;
      end
    end
  end
`endif

  assign i2c_start         = (state_q == ST_REQ);
  assign i2c_stop          = (state_q == ST_STOP_REQ);
  assign busy              = (state_q != ST_IDLE);
  assign i2c_slave_address = SLAVE_ADDR;
  assign i2c_reg_addr      = START_REG;
  assign sample_valid      = sample_valid_q;
  assign accel_x           = words_q[W_ACCEL_X];
  assign accel_y           = words_q[W_ACCEL_Y];
  assign accel_z           = words_q[W_ACCEL_Z];
  assign temp_raw          = words_q[W_TEMP];
  assign gyro_x            = words_q[W_GYRO_X];
  assign gyro_y            = words_q[W_GYRO_Y];
  assign gyro_z            = words_q[W_GYRO_Z];

endmodule

// File: tb/tb_mpu6050_burst_reader.sv
// Directed bench for mpu6050_burst_reader with a hand-driven I2C master model.
// The watchdog section runs only when MPU_READ_TIMEOUT_EN is defined.
module tb_mpu6050_burst_reader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic i2c_avail = 1'b1;
  logic i2c_avail_data = 1'b0;
  logic [7:0] i2c_data = 8'h00;
  logic i2c_start, i2c_stop, sample_valid, busy, error;
  logic [6:0] i2c_slave_address;
  logic [7:0] i2c_reg_addr;
  logic signed [15:0] accel_x, accel_y, accel_z, temp_raw, gyro_x, gyro_y, gyro_z;

  int n_checks = 0;
  int n_fail = 0;
  int vld_cnt = 0;
  int cyc, vd, seen;
  logic [7:0] tx [14];

  mpu6050_burst_reader #(.SAMPLE_PERIOD(100), .TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .i2c_start(i2c_start), .i2c_stop(i2c_stop),
    .i2c_slave_address(i2c_slave_address), .i2c_reg_addr(i2c_reg_addr),
    .i2c_data(i2c_data), .i2c_avail_data(i2c_avail_data), .i2c_avail(i2c_avail),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z), .temp_raw(temp_raw),
    .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
    .sample_valid(sample_valid), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sample_valid) vld_cnt <= vld_cnt + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_start(input int limit, output int c);
    c = 0;
    while (!i2c_start && c < limit) begin
      step(1);
      c++;
    end
    if (!i2c_start) check("start_seen", 16'(i2c_start), 16'd1);
  endtask

  task automatic begin_burst(input int n, input int hold);
    step(1);
    i2c_avail = 1'b0;
    step(1);
    check("start_drop", 16'(i2c_start), 16'd0);
    check("busy_in_burst", 16'(busy), 16'd1);
    for (int i = 0; i < n; i++) begin
      i2c_data = tx[i];
      i2c_avail_data = 1'b1;
      step(hold);
      i2c_avail_data = 1'b0;
      step(2);
    end
  endtask

  task automatic end_burst(input logic [15:0] old_ax, output int vdelta);
    int c, v0;
    c = 0;
    while (!i2c_stop && c < 50) begin
      step(1);
      c++;
    end
    check("stop_seen", 16'(i2c_stop), 16'd1);
    check("coherent_hold", accel_x, old_ax);
    v0 = vld_cnt;
    i2c_avail = 1'b1;
    step(6);
    vdelta = vld_cnt - v0;
  endtask

  initial begin
    step(3);
    check("rst_accel_x", accel_x, 16'h0000);
    check("rst_accel_y", accel_y, 16'h0000);
    check("rst_accel_z", accel_z, 16'h0000);
    check("rst_temp", temp_raw, 16'h0000);
    check("rst_gyro_x", gyro_x, 16'h0000);
    check("rst_gyro_y", gyro_y, 16'h0000);
    check("rst_gyro_z", gyro_z, 16'h0000);
    check("rst_start", 16'(i2c_start), 16'd0);
    check("rst_stop", 16'(i2c_stop), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_valid", 16'(sample_valid), 16'd0);
    check("rst_error", 16'(error), 16'd0);
    check("slave_addr", 16'(i2c_slave_address), 16'h0068);
    check("reg_addr", 16'(i2c_reg_addr), 16'h003B);

    // Burst 1: bytes 0x01..0x0E, short strobes.
    @(negedge clk);
    reset = 1'b0;
    wait_start(400, cyc);
    check("start_cycle", 16'(cyc), 16'd101);
    check("busy_at_start", 16'(busy), 16'd1);
    for (int i = 0; i < 14; i++) tx[i] = 8'(i + 1);
    begin_burst(14, 2);
    end_burst(16'h0000, vd);
    check("b1_valid_pulses", 16'(vd), 16'd1);
    check("b1_accel_x", accel_x, 16'h0102);
    check("b1_accel_y", accel_y, 16'h0304);
    check("b1_accel_z", accel_z, 16'h0506);
    check("b1_temp", temp_raw, 16'h0708);
    check("b1_gyro_x", gyro_x, 16'h090A);
    check("b1_gyro_y", gyro_y, 16'h0B0C);
    check("b1_gyro_z", gyro_z, 16'h0D0E);
    check("b1_idle", 16'(busy), 16'd0);
    check("b1_valid_low", 16'(sample_valid), 16'd0);

    // Burst 2: negative value, strobes held 6 cycles each.
    tx[0] = 8'hFF;
    tx[1] = 8'h85;
    for (int i = 2; i < 14; i++) tx[i] = 8'(8'h0E + i);
    wait_start(400, cyc);
    begin_burst(14, 6);
    enable = 1'b0;
    end_burst(16'h0102, vd);
    check("b2_valid_pulses", 16'(vd), 16'd1);
    check("b2_accel_x", accel_x, 16'hFF85);
    check("b2_accel_y", accel_y, 16'h1011);
    check("b2_temp", temp_raw, 16'h1415);
    check("b2_gyro_z", gyro_z, 16'h1A1B);

    // Disabled: pending is held, no new transaction starts.
    seen = 0;
    for (int i = 0; i < 250; i++) begin
      step(1);
      if (i2c_start) seen = 1;
    end
    check("disabled_no_start", 16'(seen), 16'd0);
    check("disabled_idle", 16'(busy), 16'd0);
    enable = 1'b1;
    wait_start(5, cyc);
    check("pending_resume", 16'(cyc), 16'd1);

    // Reset after the 5th byte, then a fresh full burst.
    for (int i = 0; i < 14; i++) tx[i] = 8'(8'h21 + i);
    begin_burst(5, 2);
    reset = 1'b1;
    i2c_avail = 1'b1;
    i2c_avail_data = 1'b0;
    step(3);
    check("mid_rst_busy", 16'(busy), 16'd0);
    check("mid_rst_start", 16'(i2c_start), 16'd0);
    check("mid_rst_stop", 16'(i2c_stop), 16'd0);
    check("mid_rst_accel_x", accel_x, 16'h0000);
    check("mid_rst_gyro_z", gyro_z, 16'h0000);
    reset = 1'b0;
    wait_start(400, cyc);
    check("mid_rst_restart", 16'(cyc), 16'd101);
    begin_burst(14, 2);
    end_burst(16'h0000, vd);
    check("b3_valid_pulses", 16'(vd), 16'd1);
    check("b3_accel_x", accel_x, 16'h2122);
    check("b3_temp", temp_raw, 16'h2728);
    check("b3_gyro_z", gyro_z, 16'h2D2E);

`ifdef MPU_READ_TIMEOUT_EN
    // Master stalls after byte 3: watchdog forces stop, no publish.
    for (int i = 0; i < 14; i++) tx[i] = 8'(8'hA0 + i);
    wait_start(400, cyc);
    begin_burst(3, 2);
    cyc = 14;
    while (!i2c_stop && cyc < 1500) begin
      step(1);
      cyc++;
    end
    check("to_stop_seen", 16'(i2c_stop), 16'd1);
    check("to_stop_cycle", 16'(cyc), 16'd1000);
    check("to_error", 16'(error), 16'd1);
    vd = vld_cnt;
    enable = 1'b0;
    i2c_avail = 1'b1;
    step(4);
    check("to_idle", 16'(busy), 16'd0);
    check("to_no_valid", 16'(vld_cnt - vd), 16'd0);
    check("to_accel_x_hold", accel_x, 16'h2122);
    check("to_gyro_z_hold", gyro_z, 16'h2D2E);
    check("to_error_sticky", 16'(error), 16'd1);
`else
    check("no_wd_error", 16'(error), 16'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
